// File: rtl/hello_world_qsys_nios_cpu_debug_host_if.sv
// Command/response channel of the debug-host scan initiator.
//   master : issues cmd_valid/cmd_ir/cmd_dr, receives cmd_ready and rsp_*
//   slave  : the scan initiator itself
// cmd accept = cmd_valid & cmd_ready; rsp_valid is a one-clk pulse and
// rsp_dr/rsp_ir_out hold until the next completed scan or reset.
interface hello_world_qsys_nios_cpu_debug_host_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );
endinterface

// File: rtl/hello_world_qsys_nios_cpu_debug_host.sv
// Scan-chain initiator standing in for the virtual-JTAG hub in front of the
// Nios II debug slave. One accepted command becomes a full UIR->CDR->SDR->UDR
// scan; the shifted-out DR word and the ir_out seen during UIR are returned.
// Ports:
//   i_clk, i_reset      : system clock, synchronous active-high reset
//   bus (slave modport) : cmd_valid/ready/ir/dr in, rsp_valid/dr/ir_out out
//   o_tck, o_tdi, i_tdo : generated scan clock and serial data
//   o_ir_in, i_ir_out   : virtual IR to / status from the debug slave
//   o_vs_uir/cdr/sdr/udr: virtual state flags (one-hot while busy)
//   o_jtag_state_rti    : high only while idle
//   o_busy              : scan in progress
module hello_world_qsys_nios_cpu_debug_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_HALF = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  hello_world_qsys_nios_cpu_debug_host_if.slave bus,
  output logic                o_tck,
  output logic                o_tdi,
  input  logic                i_tdo,
  output logic [IR_WIDTH-1:0] o_ir_in,
  input  logic [IR_WIDTH-1:0] i_ir_out,
  output logic                o_vs_uir,
  output logic                o_vs_cdr,
  output logic                o_vs_sdr,
  output logic                o_vs_udr,
  output logic                o_jtag_state_rti,
  output logic                o_busy
);

  localparam int PH_W  = $clog2(2 * TCK_HALF);
  localparam int BIT_W = $clog2(DR_WIDTH + 1);
  localparam logic [PH_W-1:0]  PH_RISE = PH_W'(TCK_HALF - 1);
  localparam logic [PH_W-1:0]  PH_END  = PH_W'(2 * TCK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_END = BIT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR} state_t;

  state_t              r_state;
  logic [PH_W-1:0]     r_ph;      // clk position inside the current tck period
  logic [BIT_W-1:0]    r_bit;
  logic [DR_WIDTH-1:0] r_dr;      // latched DR, shifted right as bits go out
  logic [DR_WIDTH-1:0] r_cap;     // tdo collected MSB-first, lands LSB-aligned
  logic [IR_WIDTH-1:0] r_ir_cap;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic                r_tck, r_tdi;
  logic                r_vs_uir, r_vs_cdr, r_vs_sdr, r_vs_udr, r_rti;
  logic                r_rsp_valid;
  logic [DR_WIDTH-1:0] r_rsp_dr;
  logic [IR_WIDTH-1:0] r_rsp_ir;

  logic w_idle, w_accept, w_rise, w_pend;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = bus.cmd_valid & bus.cmd_ready;
  assign w_rise   = (r_ph == PH_RISE);  // this edge drives tck high
  assign w_pend   = (r_ph == PH_END);   // this edge drives tck low: next period

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_ph        <= '0;
      r_bit       <= '0;
      r_dr        <= '0;
      r_cap       <= '0;
      r_ir_cap    <= '0;
      r_ir_in     <= '0;
      r_tck       <= 1'b0;
      r_tdi       <= 1'b0;
      r_vs_uir    <= 1'b0;
      r_vs_cdr    <= 1'b0;
      r_vs_sdr    <= 1'b0;
      r_vs_udr    <= 1'b0;
      r_rti       <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_dr    <= '0;
      r_rsp_ir    <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_dr     <= bus.cmd_dr;
          r_ir_in  <= bus.cmd_ir;
          r_cap    <= '0;
          r_bit    <= '0;
          r_ph     <= '0;
          r_tck    <= 1'b0;
          r_tdi    <= 1'b0;
          r_vs_uir <= 1'b1;
          r_rti    <= 1'b0;
          r_state  <= S_UIR;
        end
      end else begin
        r_ph <= w_pend ? '0 : r_ph + 1'b1;
        // Sample before the slave sees the rising tck edge.
        if (w_rise) begin
          r_tck <= 1'b1;
          if (r_state == S_UIR) r_ir_cap <= i_ir_out;
          if (r_state == S_SDR) r_cap <= {i_tdo, r_cap[DR_WIDTH-1:1]};
        end
        if (w_pend) begin
          r_tck <= 1'b0;
          case (r_state)
            S_UIR: begin
              r_vs_uir <= 1'b0;
              r_vs_cdr <= 1'b1;
              r_tdi    <= 1'b0;
              r_state  <= S_CDR;
            end
            S_CDR: begin
              r_vs_cdr <= 1'b0;
              r_vs_sdr <= 1'b1;
              r_tdi    <= r_dr[0];
              r_bit    <= '0;
              r_state  <= S_SDR;
            end
            S_SDR: begin
              if (r_bit == BIT_END) begin
                r_vs_sdr <= 1'b0;
                r_vs_udr <= 1'b1;
                r_tdi    <= 1'b0;
                r_state  <= S_UDR;
              end else begin
                r_bit <= r_bit + 1'b1;
                r_dr  <= r_dr >> 1;
                r_tdi <= r_dr[1];
              end
            end
            S_UDR: begin
              r_vs_udr    <= 1'b0;
              r_rti       <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_dr    <= r_cap;
              r_rsp_ir    <= r_ir_cap;
              r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Combinational so a command can be taken on the very first cycle after
  // reset and in the same cycle rsp_valid pulses.
  assign bus.cmd_ready  = w_idle & ~i_reset;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_dr     = r_rsp_dr;
  assign bus.rsp_ir_out = r_rsp_ir;

  assign o_tck            = r_tck;
  assign o_tdi            = r_tdi;
  assign o_ir_in          = r_ir_in;
  assign o_vs_uir         = r_vs_uir;
  assign o_vs_cdr         = r_vs_cdr;
  assign o_vs_sdr         = r_vs_sdr;
  assign o_vs_udr         = r_vs_udr;
  assign o_jtag_state_rti = r_rti;
  assign o_busy           = ~w_idle;

endmodule

// File: tb/tb_hello_world_qsys_nios_cpu_debug_host.sv
module tb_hello_world_qsys_nios_cpu_debug_host;
  localparam int DRW = 38;
  localparam int IRW = 2;
  localparam logic [DRW-1:0] PRE = 38'h15_5555_5555;
  localparam logic [DRW-1:0] DA  = 38'h2A_AAAA_AAAA;
  localparam logic [DRW-1:0] D1  = 38'h3F_0000_FFFF;
  localparam logic [DRW-1:0] D2  = 38'h00_DEAD_BEEF;
  localparam logic [DRW-1:0] D3  = 38'h01_2345_6789;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int             cyc;
    logic [DRW-1:0] dr;
    logic [IRW-1:0] ir_out;
    logic [DRW-1:0] sr;
    logic [IRW-1:0] ir_in;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // ---------------- DUT0: TCK_HALF=2 ----------------
  hello_world_qsys_nios_cpu_debug_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) b0();
  logic tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0, busy0;
  logic [IRW-1:0] irin0, irout0;

  hello_world_qsys_nios_cpu_debug_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(2)) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(b0.slave),
    .o_tck(tck0), .o_tdi(tdi0), .i_tdo(tdo0), .o_ir_in(irin0), .i_ir_out(irout0),
    .o_vs_uir(uir0), .o_vs_cdr(cdr0), .o_vs_sdr(sdr0), .o_vs_udr(udr0),
    .o_jtag_state_rti(rti0), .o_busy(busy0)
  );

  // Slave shift-register model: capture at CDR, shift LSB-out at SDR.
  logic [DRW-1:0] sr0 = '0;
  always @(posedge tck0) begin
    if (cdr0) sr0 <= PRE;
    else if (sdr0) sr0 <= {tdi0, sr0[DRW-1:1]};
  end
  assign tdo0   = sr0[0];
  assign irout0 = ~irin0;

  // ---------------- DUT1: TCK_HALF=1 ----------------
  hello_world_qsys_nios_cpu_debug_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) b1();
  logic tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1, busy1;
  logic [IRW-1:0] irin1, irout1;

  hello_world_qsys_nios_cpu_debug_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(b1.slave),
    .o_tck(tck1), .o_tdi(tdi1), .i_tdo(tdo1), .o_ir_in(irin1), .i_ir_out(irout1),
    .o_vs_uir(uir1), .o_vs_cdr(cdr1), .o_vs_sdr(sdr1), .o_vs_udr(udr1),
    .o_jtag_state_rti(rti1), .o_busy(busy1)
  );

  logic [DRW-1:0] sr1 = '0;
  always @(posedge tck1) begin
    if (cdr1) sr1 <= PRE;
    else if (sdr1) sr1 <= {tdi1, sr1[DRW-1:1]};
  end
  assign tdo1   = sr1[0];
  assign irout1 = ~irin1;

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon0
    exp_t e;
    if (b0.rsp_valid) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp0: actual rsp_valid=1 required no response (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("rsp0_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp0_dr", 64'(b0.rsp_dr), 64'(e.dr));
        chk("rsp0_ir_out", 64'(b0.rsp_ir_out), 64'(e.ir_out));
        chk("slave0_sr_at_udr", 64'(sr0), 64'(e.sr));
        chk("ir_in0", 64'(irin0), 64'(e.ir_in));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (b1.rsp_valid) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp1: actual rsp_valid=1 required no response (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("rsp1_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp1_dr", 64'(b1.rsp_dr), 64'(e.dr));
        chk("rsp1_ir_out", 64'(b1.rsp_ir_out), 64'(e.ir_out));
        chk("slave1_sr_at_udr", 64'(sr1), 64'(e.sr));
        chk("ir_in1", 64'(irin1), 64'(e.ir_in));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue0(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                        input bit exp_rsp, output int acc);
    exp_t e;
    @(negedge clk);
    b0.cmd_valid = 1'b1;
    b0.cmd_ir    = ir;
    b0.cmd_dr    = dr;
    acc = -1;
    for (int k = 0; k < 1000; k++) begin
      if (b0.cmd_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept0_timeout: actual no accept required accept within 1000 cycles");
    end else if (exp_rsp) begin
      e.cyc = acc + 165; e.dr = PRE; e.ir_out = ~ir; e.sr = dr; e.ir_in = ir;
      q0.push_back(e);
    end
    @(posedge clk);
    #1 b0.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle0();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle0_timeout: actual busy required idle within 1000 cycles");
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    int acc, acc1, acc2, bad;
    exp_t e;
    b0.cmd_valid = 1'b0; b0.cmd_ir = '0; b0.cmd_dr = '0;
    b1.cmd_valid = 1'b0; b1.cmd_ir = '0; b1.cmd_dr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single scan; also check the tck waveform over the first periods.
    issue0(2'b01, DA, 1'b1, acc);
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (tck0 !== (((k - 1) % 4) >= 2)) bad++;
    end
    chk("tck_half2_waveform", 64'(bad), 64'd0);
    wait_idle0();

    // Back-to-back with cmd_valid held high.
    @(negedge clk);
    b0.cmd_valid = 1'b1; b0.cmd_ir = 2'b10; b0.cmd_dr = D1;
    acc1 = -1;
    for (int k = 0; k < 1000; k++) begin
      if (b0.cmd_ready) begin acc1 = cyc; break; end
      @(negedge clk);
    end
    e.cyc = acc1 + 165; e.dr = PRE; e.ir_out = 2'b01; e.sr = D1; e.ir_in = 2'b10;
    q0.push_back(e);
    @(posedge clk);
    #1 b0.cmd_ir = 2'b11; b0.cmd_dr = D2;
    acc2 = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (b0.cmd_ready) begin acc2 = cyc; break; end
    end
    chk("b2b_second_accept_cycle", 64'(acc2 - acc1), 64'd165);
    chk("b2b_accept_in_rsp_cycle", 64'(b0.rsp_valid), 64'd1);
    e.cyc = acc2 + 165; e.dr = PRE; e.ir_out = 2'b00; e.sr = D2; e.ir_in = 2'b11;
    q0.push_back(e);
    @(posedge clk);
    #1 b0.cmd_valid = 1'b0;
    wait_idle0();

    // Reset held 3 cycles at a random point mid-scan.
    issue0(2'b11, 38'h0A_5A5A_0F0F, 1'b0, acc);
    repeat ($urandom_range(5, 150)) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tck", 64'(tck0), 64'd0);
    chk("rst_tdi", 64'(tdi0), 64'd0);
    chk("rst_ir_in", 64'(irin0), 64'd0);
    chk("rst_vs", 64'({uir0, cdr0, sdr0, udr0}), 64'd0);
    chk("rst_rsp_valid", 64'(b0.rsp_valid), 64'd0);
    chk("rst_rsp_dr", 64'(b0.rsp_dr), 64'd0);
    chk("rst_rsp_ir_out", 64'(b0.rsp_ir_out), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_cmd_ready", 64'(b0.cmd_ready), 64'd0);
    chk("rst_rti", 64'(rti0), 64'd1);
    rst = 1'b0;
    #1 chk("cmd_ready_after_release", 64'(b0.cmd_ready), 64'd1);

    // Reset during SDR bit 20, then a clean scan with cmd_dr=0.
    issue0(2'b10, DA, 1'b0, acc);
    while (cyc < acc + 90) @(negedge clk);
    chk("in_sdr_before_abort", 64'(sdr0), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_rti", 64'(rti0), 64'd1);
    chk("abort_vs", 64'({uir0, cdr0, sdr0, udr0, tck0, tdi0}), 64'd0);
    chk("abort_rsp_dr", 64'(b0.rsp_dr), 64'd0);
    rst = 1'b0;
    issue0(2'b00, '0, 1'b1, acc);
    wait_idle0();

    // Input changes and cmd_valid pulses while busy are ignored.
    issue0(2'b01, D3, 1'b1, acc);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      repeat (20) @(negedge clk);
      b0.cmd_dr = ~D3; b0.cmd_ir = 2'b10; b0.cmd_valid = 1'b1;
      @(negedge clk);
      b0.cmd_valid = 1'b0;
      if (irin0 !== 2'b01) bad++;
    end
    chk("ir_in_stable_while_busy", 64'(bad), 64'd0);
    wait_idle0();
    repeat (200) @(negedge clk);

    // TCK_HALF=1 instance: same command, half the latency.
    @(negedge clk);
    b1.cmd_valid = 1'b1; b1.cmd_ir = 2'b01; b1.cmd_dr = DA;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      if (b1.cmd_ready) begin acc = cyc; break; end
      @(negedge clk);
    end
    e.cyc = acc + 83; e.dr = PRE; e.ir_out = 2'b10; e.sr = DA; e.ir_in = 2'b01;
    q1.push_back(e);
    @(posedge clk);
    #1 b1.cmd_valid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (tck1 !== ((k % 2) == 0)) bad++;
    end
    chk("tck_half1_toggle", 64'(bad), 64'd0);

    // Drain both scoreboards.
    for (int k = 0; k < 1000; k++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_responses: actual %0d/%0d outstanding required 0/0", q0.size(), q1.size());
    end
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
